rob_commit_controller: RTL and testbench

//   Retire sequencer at the head of reorder_buffer. Inspects the head entry each cycle and commits it in order:
//   - ALU/LOAD results are written to the register file.
//   - STOREs are handed to the store buffer under a req/ack handshake.
//   - Exceptions trigger a timed pipeline flush with cause/PC/address capture.

---
 rtl/rob_commit_controller.sv | 141 ++++++++++++++
 tb/tb_rob_commit_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_controller.sv
// In-order retire sequencer for the reorder-buffer head: register-file writeback,
// store-buffer handoff under req/ack, and a timed flush with exception capture.
module rob_commit_controller #(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_head_ready,
    input  logic [31:0]      in_head_value,
    input  logic [31:0]      in_head_miss_addr,
    input  logic [31:0]      in_head_PC,
    input  logic [4:0]       in_head_rd,
    input  logic [2:0]       in_head_exception,
    input  logic [2:0]       in_head_instr_type,
    input  logic             in_stall,
    input  logic             in_sb_ack,
    output logic             out_rob_pop,
    output logic             out_rf_we,
    output logic [4:0]       out_rf_rd,
    output logic [31:0]      out_rf_value,
    output logic             out_sb_req,
    output logic [31:0]      out_sb_addr,
    output logic [31:0]      out_sb_data,
    output logic             out_flush,
    output logic [31:0]      out_exc_PC,
    output logic [2:0]       out_exc_cause,
    output logic [31:0]      out_exc_addr,
    output logic             out_busy,
    output logic [CNT_W-1:0] out_retired_count
);

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_STORE_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH      = 2'd2;

    localparam logic [2:0] T_ALU   = 3'b000;
    localparam logic [2:0] T_LOAD  = 3'b001;
    localparam logic [2:0] T_STORE = 3'b010;

    logic [1:0]       r_state;
    logic [FC_W-1:0]  r_flush_cnt;
    logic [31:0]      r_exc_pc;
    logic [2:0]       r_exc_cause;
    logic [31:0]      r_exc_addr;
    logic [CNT_W-1:0] r_retired_count;

    logic [1:0]       w_next_state;
    logic             w_retire;
    logic             w_take_exc;

    // Valid/ready contract: out_sb_req is held with stable addr/data until the
    // cycle in_sb_ack is seen; that same cycle pops the ROB head and retires it.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_take_exc   = 1'b0;
        out_rob_pop  = 1'b0;
        out_rf_we    = 1'b0;
        out_rf_rd    = 5'd0;
        out_rf_value = 32'd0;
        out_sb_req   = 1'b0;
        out_sb_addr  = 32'd0;
        out_sb_data  = 32'd0;
        out_flush    = 1'b0;
        out_busy     = 1'b0;
        if (!reset) begin
            out_busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (in_head_ready && !in_stall) begin
                        if (in_head_exception != 3'd0) begin
                            out_rob_pop  = 1'b1;
                            w_take_exc   = 1'b1;
                            w_next_state = S_FLUSH;
                        end else if (in_head_instr_type == T_STORE) begin
                            w_next_state = S_STORE_WAIT;
                        end else begin
                            out_rob_pop = 1'b1;
                            w_retire    = 1'b1;
                            if (in_head_instr_type == T_ALU || in_head_instr_type == T_LOAD) begin
                                out_rf_we    = (in_head_rd != 5'd0);
                                out_rf_rd    = in_head_rd;
                                out_rf_value = in_head_value;
                            end
                        end
                    end
                end
                S_STORE_WAIT: begin
                    out_sb_req  = 1'b1;
                    out_sb_addr = in_head_miss_addr;
                    out_sb_data = in_head_value;
                    if (in_sb_ack) begin
                        out_rob_pop  = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    out_flush = 1'b1;
                    if (r_flush_cnt == FC_W'(1)) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_flush_cnt     <= '0;
            r_exc_pc        <= 32'd0;
            r_exc_cause     <= 3'd0;
            r_exc_addr      <= 32'd0;
            r_retired_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_take_exc) begin
                r_flush_cnt <= FC_W'(FLUSH_CYCLES);
                r_exc_pc    <= in_head_PC;
                r_exc_cause <= in_head_exception;
                r_exc_addr  <= in_head_miss_addr;
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - FC_W'(1);
            end
            if (w_retire) begin
                r_retired_count <= r_retired_count + CNT_W'(1);
            end
        end
    end

    assign out_exc_PC        = r_exc_pc;
    assign out_exc_cause     = r_exc_cause;
    assign out_exc_addr      = r_exc_addr;
    assign out_retired_count = r_retired_count;

endmodule

// File: tb/tb_rob_commit_controller.sv
// Directed bench for rob_commit_controller: register-file and store handoffs are
// checked against expected queues; strobes and captured state are checked per cycle.
module tb_rob_commit_controller;

    logic        clk;
    logic        reset;
    logic        in_head_ready;
    logic [31:0] in_head_value;
    logic [31:0] in_head_miss_addr;
    logic [31:0] in_head_PC;
    logic [4:0]  in_head_rd;
    logic [2:0]  in_head_exception;
    logic [2:0]  in_head_instr_type;
    logic        in_stall;
    logic        in_sb_ack;
    logic        out_rob_pop;
    logic        out_rf_we;
    logic [4:0]  out_rf_rd;
    logic [31:0] out_rf_value;
    logic        out_sb_req;
    logic [31:0] out_sb_addr;
    logic [31:0] out_sb_data;
    logic        out_flush;
    logic [31:0] out_exc_PC;
    logic [2:0]  out_exc_cause;
    logic [31:0] out_exc_addr;
    logic        out_busy;
    logic [31:0] out_retired_count;

    rob_commit_controller #(.FLUSH_CYCLES(3), .CNT_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_head_ready     (in_head_ready),
        .in_head_value     (in_head_value),
        .in_head_miss_addr (in_head_miss_addr),
        .in_head_PC        (in_head_PC),
        .in_head_rd        (in_head_rd),
        .in_head_exception (in_head_exception),
        .in_head_instr_type(in_head_instr_type),
        .in_stall          (in_stall),
        .in_sb_ack         (in_sb_ack),
        .out_rob_pop       (out_rob_pop),
        .out_rf_we         (out_rf_we),
        .out_rf_rd         (out_rf_rd),
        .out_rf_value      (out_rf_value),
        .out_sb_req        (out_sb_req),
        .out_sb_addr       (out_sb_addr),
        .out_sb_data       (out_sb_data),
        .out_flush         (out_flush),
        .out_exc_PC        (out_exc_PC),
        .out_exc_cause     (out_exc_cause),
        .out_exc_addr      (out_exc_addr),
        .out_busy          (out_busy),
        .out_retired_count (out_retired_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_count = 0;
    logic [36:0] exp_rf_q[$];
    logic [63:0] exp_sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_head(input logic rdy, input logic [2:0] typ, input logic [4:0] rd,
                              input logic [31:0] val, input logic [31:0] addr,
                              input logic [31:0] pc, input logic [2:0] exc);
        in_head_ready      = rdy;
        in_head_instr_type = typ;
        in_head_rd         = rd;
        in_head_value      = val;
        in_head_miss_addr  = addr;
        in_head_PC         = pc;
        in_head_exception  = exc;
    endtask

    // Scoreboard: pops expected handoffs as the DUT produces them.
    always @(negedge clk) begin
        if (out_rf_we) begin
            if (exp_rf_q.size() == 0) chk("rf_unexpected", 64'({out_rf_rd, out_rf_value}), 64'd0);
            else chk("rf_write", 64'({out_rf_rd, out_rf_value}), 64'(exp_rf_q.pop_front()));
        end
        if (out_sb_req && in_sb_ack) begin
            if (exp_sb_q.size() == 0) chk("sb_unexpected", {out_sb_addr, out_sb_data}, 64'd0);
            else chk("sb_handoff", {out_sb_addr, out_sb_data}, exp_sb_q.pop_front());
        end
    end

    initial begin
        logic [31:0] rnd;
        reset     = 1'b1;
        in_stall  = 1'b0;
        in_sb_ack = 1'b0;
        drive_head(1'b1, 3'b000, 5'd7, 32'h1111_1111, 32'd0, 32'd0, 3'd0);

        // Reset: strobes low even with a ready head, registered state zero
        tick();
        @(negedge clk);
        chk("reset_pop", 64'(out_rob_pop), 64'd0);
        chk("reset_rf_we", 64'(out_rf_we), 64'd0);
        chk("reset_busy", 64'(out_busy), 64'd0);
        chk("reset_count", 64'(out_retired_count), 64'd0);
        chk("reset_exc_cause", 64'(out_exc_cause), 64'd0);
        chk("reset_exc_pc", 64'(out_exc_PC), 64'd0);

        // ALU rd=1 DEADBEEF
        tick();
        reset = 1'b0;
        drive_head(1'b1, 3'b000, 5'd1, 32'hDEAD_BEEF, 32'd0, 32'h100, 3'd0);
        exp_rf_q.push_back({5'd1, 32'hDEAD_BEEF});
        exp_count++;
        @(negedge clk);
        chk("alu_pop", 64'(out_rob_pop), 64'd1);
        chk("alu_rf_we", 64'(out_rf_we), 64'd1);

        // ALU rd=0: retires without a write
        tick();
        chk("alu_count", 64'(out_retired_count), 64'(exp_count));
        drive_head(1'b1, 3'b000, 5'd0, 32'h1234_5678, 32'd0, 32'h104, 3'd0);
        exp_count++;
        @(negedge clk);
        chk("rd0_pop", 64'(out_rob_pop), 64'd1);
        chk("rd0_rf_we", 64'(out_rf_we), 64'd0);

        // LOAD with random data
        tick();
        rnd = $urandom;
        drive_head(1'b1, 3'b001, 5'd5, rnd, 32'h40, 32'h108, 3'd0);
        exp_rf_q.push_back({5'd5, rnd});
        exp_count++;
        @(negedge clk);
        chk("load_pop", 64'(out_rob_pop), 64'd1);

        // No-writeback type
        tick();
        drive_head(1'b1, 3'b101, 5'd9, 32'h5555_AAAA, 32'd0, 32'h10C, 3'd0);
        exp_count++;
        @(negedge clk);
        chk("nowb_pop", 64'(out_rob_pop), 64'd1);
        chk("nowb_rf_we", 64'(out_rf_we), 64'd0);

        // STORE addr=1000 data=CAFEBABE: IDLE cycle, then ack on the 3rd STORE_WAIT cycle
        tick();
        chk("pre_store_count", 64'(out_retired_count), 64'(exp_count));
        drive_head(1'b1, 3'b010, 5'd0, 32'hCAFE_BABE, 32'h1000, 32'h110, 3'd0);
        exp_sb_q.push_back({32'h1000, 32'hCAFE_BABE});
        @(negedge clk);
        chk("store_idle_pop", 64'(out_rob_pop), 64'd0);
        chk("store_idle_req", 64'(out_sb_req), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            in_stall  = (i == 1);
            in_sb_ack = (i == 2);
            @(negedge clk);
            chk("store_req", 64'(out_sb_req), 64'd1);
            chk("store_bus", {out_sb_addr, out_sb_data}, {32'h1000, 32'hCAFE_BABE});
            chk("store_busy", 64'(out_busy), 64'd1);
            chk("store_pop", 64'(out_rob_pop), 64'(i == 2));
        end
        exp_count++;
        tick();
        in_sb_ack = 1'b0;
        in_stall  = 1'b0;
        drive_head(1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("store_done_busy", 64'(out_busy), 64'd0);
        chk("store_done_count", 64'(out_retired_count), 64'(exp_count));

        // Exception cause=1 PC=1008 addr=FFFF0000; a ready ALU head waits behind the flush
        tick();
        drive_head(1'b1, 3'b000, 5'd3, 32'h3333_3333, 32'hFFFF_0000, 32'h1008, 3'd1);
        @(negedge clk);
        chk("exc_pop", 64'(out_rob_pop), 64'd1);
        chk("exc_rf_we", 64'(out_rf_we), 64'd0);
        chk("exc_flush_early", 64'(out_flush), 64'd0);
        tick();
        drive_head(1'b1, 3'b000, 5'd2, 32'h2222_2222, 32'd0, 32'h100C, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_on", 64'(out_flush), 64'd1);
            chk("flush_pop", 64'(out_rob_pop), 64'd0);
            chk("flush_rf_we", 64'(out_rf_we), 64'd0);
            chk("flush_exc", {out_exc_PC, 29'd0, out_exc_cause}, {32'h1008, 32'd1});
            chk("flush_exc_addr", 64'(out_exc_addr), 64'hFFFF_0000);
            chk("flush_count", 64'(out_retired_count), 64'(exp_count));
            if (i < 2) tick();
        end
        exp_rf_q.push_back({5'd2, 32'h2222_2222});
        exp_count++;
        tick();
        @(negedge clk);
        chk("flush_off", 64'(out_flush), 64'd0);
        chk("post_flush_pop", 64'(out_rob_pop), 64'd1);

        // Stall two cycles with ready ALU heads, then four back-to-back commits
        tick();
        in_stall = 1'b1;
        drive_head(1'b1, 3'b000, 5'd10, 32'hA0, 32'd0, 32'h2000, 3'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_pop", 64'(out_rob_pop), 64'd0);
            chk("stall_rf_we", 64'(out_rf_we), 64'd0);
            tick();
        end
        in_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rnd = $urandom_range(32'hFFFF, 1);
            drive_head(1'b1, 3'b000, 5'(10 + i), rnd, 32'd0, 32'(32'h2000 + 4 * i), 3'd0);
            exp_rf_q.push_back({5'(10 + i), rnd});
            exp_count++;
            @(negedge clk);
            chk("b2b_pop", 64'(out_rob_pop), 64'd1);
            tick();
        end
        drive_head(1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("b2b_count", 64'(out_retired_count), 64'(exp_count));

        // Reset in the 2nd STORE_WAIT cycle
        tick();
        drive_head(1'b1, 3'b010, 5'd0, 32'h7777_0000, 32'h2000, 32'h3000, 3'd0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("sw1_req", 64'(out_sb_req), 64'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_sw_req", 64'(out_sb_req), 64'd0);
        chk("rst_sw_pop", 64'(out_rob_pop), 64'd0);
        chk("rst_sw_busy", 64'(out_busy), 64'd0);
        exp_count = 0;
        tick();
        reset = 1'b0;
        drive_head(1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("rst_sw_idle", 64'(out_busy), 64'd0);
        chk("rst_sw_req_after", 64'(out_sb_req), 64'd0);
        chk("rst_count", 64'(out_retired_count), 64'(exp_count));
        chk("rst_exc_cause", 64'(out_exc_cause), 64'd0);

        chk("rf_queue_drained", 64'(exp_rf_q.size()), 64'd0);
        chk("sb_queue_drained", 64'(exp_sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Bound the run in case the sequence above stalls on a clock problem.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
